fwd_operand_stage: RTL
======================

# fwd_operand_stage

Parametrised operand-forwarding and EX-input register stage for the pipelined RISC-V core. It generalises the fixed 3-source, 32-bit operand select into an XLEN-wide, self-selecting unit. For two operands it compares source registers against the EX/MEM and MEM/WB destinations and picks one of four sources per operand. It registers the result into the EX stage with valid/stall/flush control, and optionally inserts a one-cycle load-use bubble while counting bubbles.

## Interface
- XLEN, 32, datapath width
- RAW, 5, register-address width
- CNTW, 16, width of saturating bubble counter
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID-stage instruction valid
- stall  in  1  downstream hold; registers keep value
- flush  in  1  squash: output register becomes bubble
- rs1, rs2  in  RAW  ID-stage source addresses
- rf_rd1, rf_rd2  in  XLEN  register-file read data
- exm_rd  in  RAW  EX/MEM destination
- exm_wen  in  1  EX/MEM writes a register
- exm_is_load  in  1  EX/MEM instruction is a load
- exm_data  in  XLEN  EX/MEM ALU result
- mwb_rd  in  RAW  MEM/WB destination
- mwb_wen  in  1  MEM/WB writes a register
- mwb_data  in  XLEN  MEM/WB writeback data
- out_valid  out  1  EX operands valid
- op_a, op_b  out  XLEN  registered operands
- sel_a, sel_b  out  2  registered select used (00 RF, 01 EX/MEM, 10 MEM/WB, 11 zero)
- stall_req  out  1  combinational upstream hold request (load-use)
- lu_bubbles  out  CNTW  saturating count of inserted load-use bubbles

## Operation
- Per-operand select, evaluated independently for rs1 and rs2, first match wins:
  - rs==0 -> 11, value 0
  - exm_wen && exm_rd==rs -> 01, exm_data
  - mwb_wen && mwb_rd==rs -> 10, mwb_data
  - else -> 00, rf_rd
- Hazard = in_valid && exm_is_load && exm_wen && exm_rd!=0 && (exm_rd==rs1 || exm_rd==rs2).
- FSM states: RUN, LU_WAIT.
  - RUN, hazard, !stall, !flush:
    - stall_req=1
    - out_valid<=0; op_a/op_b/sel_a/sel_b <=0
    - lu_bubbles++ (saturates at all-ones)
    - -> LU_WAIT
  - RUN, no hazard, !stall: capture muxed values; out_valid<=in_valid.
  - LU_WAIT: hazard ignored, stall_req=0; capture normally; -> RUN unless stall (stay LU_WAIT while stall).
- Priority per cycle: rst > flush > stall > hazard > capture.
- flush:
  - out_valid<=0; operands and selects <=0
  - state -> RUN
  - stall_req=0 that cycle
  - counter unchanged
- stall (no flush): all registers and state hold; stall_req=0.
- Reset: out_valid=0, op_a=op_b=0, sel_a=sel_b=00, lu_bubbles=0, state RUN.
- Reset or flush in LU_WAIT returns to RUN.

## Timing
- Operand latency 1 cycle: inputs at edge N appear on op_a/op_b after edge N.
- stall_req is same-cycle combinational from inputs and state; never asserted two consecutive cycles for one instruction.
- Select/data paths purely combinational into registers; no multicycle paths.

## Configuration
- FWD_LOAD_USE_DET_EN defined: hazard detection, LU_WAIT state, stall_req and lu_bubbles as above.
- Undefined:
  - hazard forced 0; stall_req tied 0; lu_bubbles tied 0
  - FSM stays in RUN
  - EX/MEM forwarding applies even for loads; software/compiler guarantees no load-use pairs.

## Test plan
- rst=1 for 2 cycles with random inputs -> out_valid=0, op_a=op_b=0, sel=00, lu_bubbles=0.
- rs1=5, exm_rd=5 exm_wen=1 exm_data=0xAAAA0000, mwb_rd=5 mwb_wen=1 -> sel_a=01, op_a=0xAAAA0000 next cycle (EX/MEM priority).
- rs2=0, exm_rd=0 exm_wen=1 exm_data=0x1234 -> sel_b=11, op_b=0.
- (EN) exm_is_load=1 exm_rd=7, rs1=7:
  - stall_req=1 same cycle; out_valid=0 next cycle; lu_bubbles=1
  - next cycle mwb_rd=7 mwb_data=0xDEAD -> op_a=0xDEAD, sel_a=10, out_valid=1
- Capture op_a=0x11, then stall=1 for 3 cycles with changing inputs -> op_a stays 0x11; flush=1 with stall=1 -> out_valid=0, op_a=0.
- (EN) force CNTW-bit counter to all-ones via repeated hazards (CNTW=2 build: 4 hazards) -> lu_bubbles holds 3.

Source files
------------

// File: rtl/fwd_operand_stage.sv
// fwd_operand_stage: operand forwarding select plus the EX-input register stage.
// For rs1 and rs2 it independently picks the register file, EX/MEM, MEM/WB or
// a hard zero. The chosen operands and selects are then registered into EX
// under rst/flush/stall control.
// Optional feature: define FWD_LOAD_USE_DET_EN to enable load-use detection.
// This adds the LU_WAIT state, the stall_req output and the saturating
// lu_bubbles counter. Without it, those outputs are tied to zero.

module fwd_operand_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic [RAW-1:0]  exm_rd,
    input  logic            exm_wen,
    input  logic            exm_is_load,
    input  logic [XLEN-1:0] exm_data,
    input  logic [RAW-1:0]  mwb_rd,
    input  logic            mwb_wen,
    input  logic [XLEN-1:0] mwb_data,
    output logic            out_valid,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [1:0]      sel_a,
    output logic [1:0]      sel_b,
    output logic            stall_req,
    output logic [CNTW-1:0] lu_bubbles
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_EXM  = 2'b01;
    localparam logic [1:0] SEL_MWB  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    logic [1:0]      selA_d, selB_d;
    logic [XLEN-1:0] opA_d, opB_d;
    logic [1:0]      selA_q, selB_q;
    logic [XLEN-1:0] opA_q, opB_q;
    logic            outValid_q;
    logic            insertBubble;

    // The first matching rule wins: x0 reads zero, then the younger EX/MEM result, then MEM/WB.
    function automatic logic [1:0] pickSel(
        input logic [RAW-1:0] rs,
        input logic           exWen,
        input logic [RAW-1:0] exRd,
        input logic           wbWen,
        input logic [RAW-1:0] wbRd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs == '0) begin
            sel = SEL_ZERO;
        end else if (exWen && (exRd == rs)) begin
            sel = SEL_EXM;
        end else if (wbWen && (wbRd == rs)) begin
            sel = SEL_MWB;
        end
        return sel;
    endfunction

    // Turn a select code into the operand value that gets forwarded.
    function automatic logic [XLEN-1:0] muxData(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rfData,
        input logic [XLEN-1:0] exData,
        input logic [XLEN-1:0] wbData
    );
        logic [XLEN-1:0] val;
        case (sel)
            SEL_EXM:  val = exData;
            SEL_MWB:  val = wbData;
            SEL_ZERO: val = '0;
            default:  val = rfData;
        endcase
        return val;
    endfunction

    // Combinational forwarding for both operands, feeding the EX registers.
    always_comb begin
        selA_d = pickSel(rs1, exm_wen, exm_rd, mwb_wen, mwb_rd);
        selB_d = pickSel(rs2, exm_wen, exm_rd, mwb_wen, mwb_rd);
        opA_d  = muxData(selA_d, rf_rd1, exm_data, mwb_data);
        opB_d  = muxData(selB_d, rf_rd2, exm_data, mwb_data);
    end

`ifdef FWD_LOAD_USE_DET_EN
    typedef enum logic {RUN, LU_WAIT} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] bubbles_q;
    logic            hazard;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    assign hazard = in_valid && exm_is_load && exm_wen && (exm_rd != '0) &&
                    ((exm_rd == rs1) || (exm_rd == rs2));

    // A bubble is inserted only from RUN. Flush and stall both take priority over it.
    assign insertBubble = (state_q == RUN) && hazard && !stall && !flush;
    assign stall_req    = insertBubble;
    assign lu_bubbles   = bubbles_q;

    // Next-state logic: enter LU_WAIT for one cycle after a bubble. Flush always returns to RUN.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else if (!stall) begin
            case (state_q)
                RUN:     state_d = insertBubble ? LU_WAIT : RUN;
                LU_WAIT: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // State register and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            bubbles_q <= '0;
        end else begin
            state_q <= state_d;
            if (insertBubble && (bubbles_q != CNT_MAX)) begin
                bubbles_q <= bubbles_q + 1'b1;
            end
        end
    end
`else
    logic unusedLoad;

    assign unusedLoad   = exm_is_load;
    assign insertBubble = 1'b0;
    assign stall_req    = 1'b0;
    assign lu_bubbles   = '0;
`endif

    // EX input registers. Priority is rst, then flush, then stall (hold), then bubble, then capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            selA_q     <= SEL_RF;
            selB_q     <= SEL_RF;
        end else if (flush) begin
            outValid_q <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            selA_q     <= SEL_RF;
            selB_q     <= SEL_RF;
        end else if (stall) begin
            outValid_q <= outValid_q;
        end else if (insertBubble) begin
            outValid_q <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            selA_q     <= SEL_RF;
            selB_q     <= SEL_RF;
        end else begin
            outValid_q <= in_valid;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            selA_q     <= selA_d;
            selB_q     <= selB_d;
        end
    end

    assign out_valid = outValid_q;
    assign op_a      = opA_q;
    assign op_b      = opB_q;
    assign sel_a     = selA_q;
    assign sel_b     = selB_q;

endmodule
